// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Y86 SEQ execute stage that drives an external 64-bit ALU, owns the
//            condition codes and hands a registered result to memory.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int XLEN       = 64,
  parameter int STACK_STEP = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_icode,
  input  logic [3:0]      in_ifun,
  input  logic [XLEN-1:0] in_valA,
  input  logic [XLEN-1:0] in_valB,
  input  logic [XLEN-1:0] in_valC,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [1:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_ovf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_icode,
  output logic [XLEN-1:0] out_valE,
  output logic [XLEN-1:0] out_valA,
  output logic            out_cnd,
  output logic [1:0]      out_stat,
  output logic [2:0]      cc
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;

  localparam logic [XLEN-1:0] STEP_POS = XLEN'(STACK_STEP);
  localparam logic [XLEN-1:0] STEP_NEG = (~STEP_POS) + XLEN'(1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_icode_q, out_icode_d;
  logic [XLEN-1:0]   out_valE_q, out_valE_d;
  logic [XLEN-1:0]   out_valA_q, out_valA_d;
  logic              out_cnd_q, out_cnd_d;
  logic [1:0]        out_stat_q, out_stat_d;
  logic [2:0]        cc_q, cc_d;

  logic              instr_invalid;
  logic              cond_true;
  logic              accept;
  logic              zf, sf, of_flag;

  assign zf      = cc_q[2];
  assign sf      = cc_q[1];
  assign of_flag = cc_q[0];

  // Instruction legality depends on icode and on the ifun range for that icode.
  always_comb begin
    instr_invalid = 1'b0;
    case (in_icode)
      I_RRMOV, I_JXX: instr_invalid = (in_ifun > 4'd6);
      I_OPQ:          instr_invalid = (in_ifun > 4'd3);
      I_HALT, I_NOP, I_IRMOV, I_RMMOV, I_MRMOV,
      I_CALL, I_RET, I_PUSH, I_POP:
                      instr_invalid = (in_ifun != 4'd0);
      default:        instr_invalid = 1'b1;
    endcase
  end

  // Condition uses the flags as they stood before any update this cycle.
  always_comb begin
    cond_true = 1'b0;
    case (in_ifun)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = (sf ^ of_flag) | zf;
      4'd2:    cond_true = sf ^ of_flag;
      4'd3:    cond_true = zf;
      4'd4:    cond_true = ~zf;
      4'd5:    cond_true = ~(sf ^ of_flag);
      4'd6:    cond_true = ~(sf ^ of_flag) & ~zf;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    alu_in2  = '0;
    alu_in1  = '0;
    alu_ctrl = 2'b00;
    case (in_icode)
      I_RRMOV:                   alu_in2 = in_valA;
      I_OPQ:                     alu_in2 = in_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_in2 = in_valC;
      I_CALL, I_PUSH:            alu_in2 = STEP_NEG;
      I_RET, I_POP:              alu_in2 = STEP_POS;
      default:                   alu_in2 = '0;
    endcase
    case (in_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP:
               alu_in1 = in_valB;
      default: alu_in1 = '0;
    endcase
    if (in_icode == I_OPQ) begin
      alu_ctrl = in_ifun[1:0];
    end
  end

  always_comb begin
    in_ready    = (state_q == ST_RUN) & (~out_valid_q | out_ready);
    accept      = in_valid & in_ready;
    state_d     = state_q;
    cc_d        = cc_q;
    out_valid_d = out_valid_q;
    out_icode_d = out_icode_q;
    out_valE_d  = out_valE_q;
    out_valA_d  = out_valA_q;
    out_cnd_d   = out_cnd_q;
    out_stat_d  = out_stat_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_icode_d = in_icode;
      out_valE_d  = alu_out;
      out_valA_d  = in_valA;
      out_cnd_d   = ((in_icode == I_RRMOV) || (in_icode == I_JXX)) ? cond_true : 1'b0;
      if (instr_invalid) begin
        out_stat_d = STAT_INS;
        state_d    = ST_HALTED;
      end else if (in_icode == I_HALT) begin
        out_stat_d = STAT_HLT;
        state_d    = ST_HALTED;
      end else begin
        out_stat_d = STAT_AOK;
      end
      if (!instr_invalid && (in_icode == I_OPQ)) begin
        // Logical ops cannot overflow, whatever the ALU reports.
        cc_d = {(alu_out == '0), alu_out[XLEN-1], (in_ifun[1] ? 1'b0 : alu_ovf)};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cc_q        <= 3'b100;
      out_valid_q <= 1'b0;
      out_icode_q <= '0;
      out_valE_q  <= '0;
      out_valA_q  <= '0;
      out_cnd_q   <= 1'b0;
      out_stat_q  <= STAT_AOK;
    end else begin
      state_q     <= state_d;
      cc_q        <= cc_d;
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_valE_q  <= out_valE_d;
      out_valA_q  <= out_valA_d;
      out_cnd_q   <= out_cnd_d;
      out_stat_q  <= out_stat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_valE  = out_valE_q;
  assign out_valA  = out_valA_q;
  assign out_cnd   = out_cnd_q;
  assign out_stat  = out_stat_q;
  assign cc        = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_icode;
  logic [3:0]      in_ifun;
  logic [XLEN-1:0] in_valA;
  logic [XLEN-1:0] in_valB;
  logic [XLEN-1:0] in_valC;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [1:0]      alu_ctrl;
  logic [XLEN-1:0] alu_out;
  logic            alu_ovf;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_icode;
  logic [XLEN-1:0] out_valE;
  logic [XLEN-1:0] out_valA;
  logic            out_cnd;
  logic [1:0]      out_stat;
  logic [2:0]      cc;
  logic            ovf_inject;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU; ovf_inject lets the bench assert a spurious overflow.
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_out = alu_in1 + alu_in2;
      2'b01:   alu_out = alu_in1 - alu_in2;
      2'b10:   alu_out = alu_in1 & alu_in2;
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
    case (alu_ctrl)
      2'b00:   alu_ovf = (alu_in1[XLEN-1] == alu_in2[XLEN-1]) && (alu_out[XLEN-1] != alu_in1[XLEN-1]);
      2'b01:   alu_ovf = (alu_in1[XLEN-1] != alu_in2[XLEN-1]) && (alu_out[XLEN-1] != alu_in1[XLEN-1]);
      default: alu_ovf = 1'b0;
    endcase
    alu_ovf = alu_ovf | ovf_inject;
  end

  execute_stage #(.XLEN(XLEN), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_icode  (in_icode),
    .in_ifun   (in_ifun),
    .in_valA   (in_valA),
    .in_valB   (in_valB),
    .in_valC   (in_valC),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_ovf   (alu_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .out_valE  (out_valE),
    .out_valA  (out_valA),
    .out_cnd   (out_cnd),
    .out_stat  (out_stat),
    .cc        (cc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    in_valid = 1'b1;
    in_icode = ic;
    in_ifun  = fn;
    in_valA  = a;
    in_valB  = b;
    in_valC  = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_inject = 1'b0;
    in_icode = '0; in_ifun = '0; in_valA = '0; in_valB = '0; in_valC = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of a pending transfer
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
    step();
    chk("pend_valid", out_valid, 1);
    chk("pend_cc", cc, 3'b000);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_cc", cc, 3'b100);
    chk("rst_valE", out_valE, 0);
    chk("rst_stat", out_stat, 0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // subq: valB - valA
    drive(4'h6, 4'h1, 64'd10, 64'd30, 64'd0);
    #1;
    chk("sub_ctrl", alu_ctrl, 2'b01);
    chk("sub_in1", alu_in1, 64'd30);
    chk("sub_in2", alu_in2, 64'd10);
    step();
    chk("sub_valid", out_valid, 1);
    chk("sub_valE", out_valE, 64'd20);
    chk("sub_valA", out_valA, 64'd10);
    chk("sub_icode", out_icode, 4'h6);
    chk("sub_cc", cc, 3'b000);
    chk("sub_stat", out_stat, 2'b00);

    // addq with signed overflow
    drive(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0);
    step();
    chk("add_valE", out_valE, 64'h8000_0000_0000_0000);
    chk("add_cc", cc, 3'b011);

    drive(4'h7, 4'h2, 64'h55, 64'd0, 64'h123);
    step();
    chk("jl_cnd", out_cnd, 0);
    chk("jl_icode", out_icode, 4'h7);
    chk("jl_valA", out_valA, 64'h55);
    chk("jl_cc", cc, 3'b011);

    drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    step();
    chk("jge_cnd", out_cnd, 1);

    drive(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
    step();
    chk("jle_cnd", out_cnd, 0);

    // andq with an overflow indication that must be ignored
    ovf_inject = 1'b1;
    drive(4'h6, 4'h2, 64'b1011, 64'b1100, 64'd0);
    step();
    ovf_inject = 1'b0;
    chk("and_valE", out_valE, 64'd8);
    chk("and_cc", cc, 3'b000);

    drive(4'h6, 4'h3, 64'd5, 64'd5, 64'd0);
    step();
    chk("xor_valE", out_valE, 64'd0);
    chk("xor_cc", cc, 3'b100);

    drive(4'h2, 4'h4, 64'd7, 64'd99, 64'd0);
    step();
    chk("cmovne_valE", out_valE, 64'd7);
    chk("cmovne_cnd", out_cnd, 0);

    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    step();
    chk("je_cnd", out_cnd, 1);

    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    #1 chk("push_in2", alu_in2, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    chk("push_valE", out_valE, 64'hF8);
    chk("push_cc", cc, 3'b100);
    chk("push_cnd", out_cnd, 0);

    drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
    step();
    chk("pop_valE", out_valE, 64'h108);
    chk("pop_cc", cc, 3'b100);

    drive(4'h3, 4'h0, 64'd0, 64'h999, 64'h40);
    step();
    chk("irmov_valE", out_valE, 64'h40);

    drive(4'h5, 4'h0, 64'd0, 64'h1000, 64'h10);
    step();
    chk("mrmov_valE", out_valE, 64'h1010);

    // Back-pressure, then overlapped drain and accept
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
    #1 chk("bp_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_valE", out_valE, 64'h1010);
      chk("bp_icode", out_icode, 4'h5);
    end
    out_ready = 1'b1;
    #1 chk("ov_ready", in_ready, 1);
    step();
    chk("ov_valid", out_valid, 1);
    chk("ov_valE", out_valE, 64'd3);
    chk("ov_cc", cc, 3'b000);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);

    // halt
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
    step();
    chk("halt_stat", out_stat, 2'b01);
    chk("halt_valid", out_valid, 1);
    chk("halt_ready", in_ready, 0);
    drive(4'h6, 4'h3, 64'd1, 64'd1, 64'd0);
    step();
    chk("halted_valid", out_valid, 0);
    chk("halted_ready", in_ready, 0);
    step();
    chk("halted_cc", cc, 3'b000);
    chk("halted_stat", out_stat, 2'b01);

    // Invalid icode after reset
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    drive(4'hC, 4'h0, 64'd1, 64'd1, 64'd0);
    step();
    chk("insC_stat", out_stat, 2'b10);
    chk("insC_ready", in_ready, 0);
    chk("insC_cc", cc, 3'b100);

    // OPq with out-of-range ifun must not touch CC
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    drive(4'h6, 4'h4, 64'd1, 64'd1, 64'd0);
    step();
    chk("ins6_stat", out_stat, 2'b10);
    chk("ins6_cc", cc, 3'b100);
    chk("ins6_ready", in_ready, 0);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
